trace_monitor: RTL and testbench

TRACE_MONITOR -- requirements
Module: trace_monitor

---
 rtl/trace_monitor_pkg.sv | 26 ++
 rtl/trace_ram.sv | 32 +++
 rtl/trace_monitor.sv | 165 ++++++++++++++++
 tb/tb_trace_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_monitor_pkg.sv
// Shared types and constants for the trace monitor: FSM encoding, entry widths
// and the lowest-index priority helper used for breakpoint selection.
package trace_monitor_pkg;

  localparam int ENTRY_W = 64;
  localparam int PC_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Lowest set bit wins when several comparators match on the same cycle.
  function automatic logic [2:0] lowest_hit(input logic [7:0] hits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (hits[k]) idx = 3'(k);
      else         idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x ENTRY_W array, one write port, registered read port.
// Only the read data register is reset; the array itself carries no reset.
module trace_ram
  import trace_monitor_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Array write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= {ENTRY_W{1'b0}};
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_monitor.sv
// Instruction trace monitor with PC breakpoints and post-trigger capture.
// Optional step counter enabled by defining TRACE_MONITOR_STEP_CNT_EN.
module trace_monitor
  import trace_monitor_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_BP = 2,
  parameter int POST   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic [31:0]          instr_i,
  input  logic [PC_W*NUM_BP-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]    bp_en_i,
  input  logic                 arm_i,
  input  logic                 clear_i,
  input  logic                 rd_en_i,
  output logic [ENTRY_W-1:0]   rd_data_o,
  output logic                 rd_valid_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 halt_o,
  output logic [2:0]           hit_idx_o,
  output logic [1:0]           state_o,
  output logic [31:0]          step_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] POST_CNT = CW'(POST);

  state_t          state, next_state;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, post_cnt;
  logic [2:0]      hit_idx;
  logic            rd_valid;
  logic [7:0]      hit_vec;
  logic            hit_any, capture, pop, arm_go;

  // Breakpoint compare and per-cycle action decode; clear_i suppresses all actions
  always_comb begin
    hit_vec = 8'd0;
    for (int k = 0; k < NUM_BP; k++) begin
      hit_vec[k] = bp_en_i[k] && (bp_addr_i[PC_W*k +: PC_W] == pc_i);
    end
    hit_any = valid_i && (state == ST_ARMED) && (hit_vec != 8'd0) && !clear_i;
    capture = valid_i && ((state == ST_ARMED) || (state == ST_POST)) && !clear_i;
    pop     = rd_en_i && (state == ST_HALTED) && (count != {CW{1'b0}}) && !clear_i;
    arm_go  = arm_i && (state == ST_IDLE) && !clear_i;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (clear_i) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm_i) next_state = ST_ARMED;
          else       next_state = ST_IDLE;
        end
        ST_ARMED: begin
          if (hit_any) next_state = (POST == 0) ? ST_HALTED : ST_POST;
          else         next_state = ST_ARMED;
        end
        ST_POST: begin
          if (capture && (post_cnt == CW'(1))) next_state = ST_HALTED;
          else                                 next_state = ST_POST;
        end
        ST_HALTED: next_state = ST_HALTED;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Circular buffer pointers, occupancy and read-valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      rd_valid <= 1'b0;
    end else if (clear_i) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      count    <= {CW{1'b0}};
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (arm_go) begin
        wr_ptr <= {AW{1'b0}};
        rd_ptr <= {AW{1'b0}};
        count  <= {CW{1'b0}};
      end else if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
        // A full buffer overwrites its oldest entry
        if (count == FULL_CNT) rd_ptr <= rd_ptr + AW'(1);
        else                   count  <= count + CW'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end
    end
  end

  // Trigger index capture and post-trigger countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_idx  <= 3'd0;
      post_cnt <= {CW{1'b0}};
    end else if (hit_any) begin
      hit_idx  <= lowest_hit(hit_vec);
      post_cnt <= POST_CNT;
    end else if (capture && (state == ST_POST)) begin
      post_cnt <= post_cnt - CW'(1);
    end
  end

`ifdef TRACE_MONITOR_STEP_CNT_EN
  logic [31:0] step_cnt;

  // Retired-instruction counter, zeroed on arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          step_cnt <= 32'd0;
    else if (arm_go)  step_cnt <= 32'd0;
    else if (capture) step_cnt <= step_cnt + 32'd1;
  end

  assign step_cnt_o = step_cnt;
`else
  assign step_cnt_o = 32'd0;
`endif

  trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata ({pc_i, instr_i}),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_data_o)
  );

  assign rd_valid_o = rd_valid;
  assign empty_o    = (count == {CW{1'b0}});
  assign full_o     = (count == FULL_CNT);
  assign halt_o     = (state == ST_HALTED);
  assign hit_idx_o  = hit_idx;
  assign state_o    = state;

endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor: a POST=4 instance and a POST=0 instance
// share stimulus; expected values are hand-derived per scenario.
module tb_trace_monitor;

  logic        clk = 1'b0;
  logic        rst, valid_i, arm_i, clear_i, rd_en_i;
  logic [31:0] pc_i, instr_i;
  logic [63:0] bp_addr_i;
  logic [1:0]  bp_en_i;

  logic [63:0] rd_data,  rd_data0;
  logic        rd_valid, rd_valid0, empty, empty0, full, full0, halt, halt0;
  logic [2:0]  hit_idx,  hit_idx0;
  logic [1:0]  state,    state0;
  logic [31:0] step_cnt, step_cnt0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  trace_monitor #(.DEPTH(16), .NUM_BP(2), .POST(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i), .arm_i(arm_i), .clear_i(clear_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .empty_o(empty), .full_o(full), .halt_o(halt), .hit_idx_o(hit_idx),
    .state_o(state), .step_cnt_o(step_cnt)
  );

  trace_monitor #(.DEPTH(16), .NUM_BP(2), .POST(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
    .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i), .arm_i(arm_i), .clear_i(clear_i),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data0), .rd_valid_o(rd_valid0),
    .empty_o(empty0), .full_o(full0), .halt_o(halt0), .hit_idx_o(hit_idx0),
    .state_o(state0), .step_cnt_o(step_cnt0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] exp_step(input logic [31:0] n);
`ifdef TRACE_MONITOR_STEP_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc);
    valid_i = 1'b1;
    pc_i    = pc;
    instr_i = instr_of(pc);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; arm_i = 1'b0; clear_i = 1'b0; rd_en_i = 1'b0;
    pc_i = 32'd0; instr_i = 32'd0; bp_addr_i = 64'd0; bp_en_i = 2'b00;
    tick(); tick();

    // Reset state
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full",  {63'd0, full},  64'd0);
    check("rst_halt",  {63'd0, halt},  64'd0);
    check("rst_rdv",   {63'd0, rd_valid}, 64'd0);
    check("rst_step",  {32'd0, step_cnt}, 64'd0);
    rst = 1'b0;
    tick();

    // Breakpoint at 0x48 with four post-trigger captures
    bp_addr_i = {32'h0000_0000, 32'h0000_0048};
    bp_en_i   = 2'b01;
    pulse_arm();
    check("arm_state", {62'd0, state}, 64'd1);
    for (int i = 0; i < 23; i++) begin
      retire(32'(i * 4));
      if (i == 18) begin
        check("hit_state", {62'd0, state}, 64'd2);
        check("hit_idx",   {61'd0, hit_idx}, 64'd0);
      end
      if (i == 21) check("post_state", {62'd0, state}, 64'd2);
    end
    check("halt_state", {62'd0, state}, 64'd3);
    check("halt_o",     {63'd0, halt},  64'd1);
    check("halt_full",  {63'd0, full},  64'd1);
    check("step_23",    {32'd0, step_cnt}, {32'd0, exp_step(32'd23)});
    rd_en_i = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      check("pop_valid", {63'd0, rd_valid}, 64'd1);
      check("pop_data",  rd_data, {32'((7 + j) * 4), instr_of(32'((7 + j) * 4))});
    end
    rd_en_i = 1'b0;
    tick();
    check("drain_empty", {63'd0, empty}, 64'd1);
    check("drain_rdv",   {63'd0, rd_valid}, 64'd0);
    // Pop on empty while halted
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("empty_pop_rdv",   {63'd0, rd_valid}, 64'd0);
    check("empty_pop_empty", {63'd0, empty}, 64'd1);
    check("empty_pop_state", {62'd0, state}, 64'd3);

    // No breakpoints: 20 retires wrap the buffer, never halt
    pulse_clear();
    check("clr_state", {62'd0, state}, 64'd0);
    check("clr_halt",  {63'd0, halt},  64'd0);
    bp_en_i = 2'b00;
    pulse_arm();
    for (int i = 0; i < 20; i++) retire(32'(32'h100 + i * 4));
    check("nobp_state", {62'd0, state}, 64'd1);
    check("nobp_full",  {63'd0, full},  64'd1);
    check("nobp_halt",  {63'd0, halt},  64'd0);
    check("nobp_step",  {32'd0, step_cnt}, {32'd0, exp_step(32'd20)});
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("armed_pop_rdv",  {63'd0, rd_valid}, 64'd0);
    check("armed_pop_full", {63'd0, full}, 64'd1);

    // Dual hit at 0x10; POST=0 instance halts on the capturing edge
    pulse_clear();
    bp_addr_i = {32'h0000_0010, 32'h0000_0010};
    bp_en_i   = 2'b11;
    pulse_arm();
    for (int i = 0; i < 5; i++) retire(32'(i * 4));
    check("p0_state",   {62'd0, state0}, 64'd3);
    check("p0_halt",    {63'd0, halt0},  64'd1);
    check("p0_hit_idx", {61'd0, hit_idx0}, 64'd0);
    check("p4_state",   {62'd0, state}, 64'd2);
    rd_en_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("p0_pop", rd_data0, {32'(j * 4), instr_of(32'(j * 4))});
    end
    rd_en_i = 1'b0;
    tick();
    check("p0_empty", {63'd0, empty0}, 64'd1);

    // Only comparator 1 enabled: index must follow the matching comparator
    pulse_clear();
    bp_addr_i = {32'h0000_0008, 32'h0000_0008};
    bp_en_i   = 2'b10;
    pulse_arm();
    for (int i = 0; i < 3; i++) retire(32'(i * 4));
    check("bp1_hit_idx", {61'd0, hit_idx0}, 64'd1);

    // clear beats arm/valid/rd_en in POST
    pulse_clear();
    bp_addr_i = {32'h0000_0000, 32'h0000_0048};
    bp_en_i   = 2'b01;
    pulse_arm();
    for (int i = 0; i < 19; i++) retire(32'(i * 4));
    check("pre_clr_state", {62'd0, state}, 64'd2);
    clear_i = 1'b1; arm_i = 1'b1; valid_i = 1'b1; rd_en_i = 1'b1;
    pc_i = 32'h4C; instr_i = instr_of(32'h4C);
    tick();
    clear_i = 1'b0; arm_i = 1'b0; valid_i = 1'b0; rd_en_i = 1'b0;
    check("clrarm_state", {62'd0, state}, 64'd0);
    check("clrarm_empty", {63'd0, empty}, 64'd1);
    check("clrarm_halt",  {63'd0, halt},  64'd0);
    pulse_arm();
    check("rearm_state", {62'd0, state}, 64'd1);
    check("rearm_step",  {32'd0, step_cnt}, 64'd0);

    // Async reset mid-readout with 5 entries remaining
    for (int i = 0; i < 23; i++) retire(32'(i * 4));
    check("r_halt", {63'd0, halt}, 64'd1);
    rd_en_i = 1'b1;
    for (int j = 0; j < 11; j++) tick();
    check("r_last_pop", rd_data, {32'h44, instr_of(32'h44)});
    #2 rst = 1'b1;
    #1;
    check("ar_state", {62'd0, state}, 64'd0);
    check("ar_empty", {63'd0, empty}, 64'd1);
    check("ar_full",  {63'd0, full},  64'd0);
    check("ar_halt",  {63'd0, halt},  64'd0);
    check("ar_rdv",   {63'd0, rd_valid}, 64'd0);
    check("ar_rdata", rd_data, 64'd0);
    check("ar_hit",   {61'd0, hit_idx}, 64'd0);
    check("ar_step",  {32'd0, step_cnt}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_pop_rdv",   {63'd0, rd_valid}, 64'd0);
    check("idle_pop_empty", {63'd0, empty}, 64'd1);
    rd_en_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
